// File: rtl/sal_bk_pkg.sv
// Shared types and constants for the per-bank DDR2 controller (sal_bk_ctrl).
// Holds the bank state encoding, the default timing values and the timer helpers.
package sal_bk_pkg;

   localparam int TMR_W = 5;

   localparam int DEF_T_RCD = 3;
   localparam int DEF_T_RP  = 3;
   localparam int DEF_T_RAS = 9;
   localparam int DEF_T_RTP = 2;
   localparam int DEF_T_WR  = 6;
   localparam int DEF_T_CCD = 2;
   localparam int DEF_T_RFC = 26;

   typedef enum logic [2:0] {
      BK_IDLE,
      BK_ACTIVATING,
      BK_ACTIVE,
      BK_PRECHARGING,
      BK_REFRESHING
   } bk_state_t;

   // Slots in the timer array; RPF is shared by tRP and tRFC.
   localparam int TMR_RCD = 0;
   localparam int TMR_RAS = 1;
   localparam int TMR_RTP = 2;
   localparam int TMR_WR  = 3;
   localparam int TMR_CCD = 4;
   localparam int TMR_RPF = 5;
   localparam int TMR_CNT = 6;

   // A grant at cycle N loads T-1 so the timer reads zero at cycle N+T.
   function automatic logic [TMR_W-1:0] tmr_ld(input int t);
      return (t > 1) ? TMR_W'(t - 1) : '0;
   endfunction

endpackage

// File: rtl/sal_bk_ctrl_if.sv
// Request/command bundle between the request decoder, one bank controller
// and the command scheduler.
interface sal_bk_ctrl_if #(
   parameter int ROW_W = 14,
   parameter int COL_W = 10
);
   logic             req_valid;
   logic             req_ready;
   logic             req_wr;
   logic [ROW_W-1:0] req_row;
   logic [COL_W-1:0] req_col;
   logic             ref_tick;

   logic             act_req;
   logic             rd_req;
   logic             wr_req;
   logic             pre_req;
   logic             ref_req;
   logic             act_gnt;
   logic             rd_gnt;
   logic             wr_gnt;
   logic             pre_gnt;
   logic             ref_gnt;

   logic [ROW_W-1:0] cmd_row;
   logic [COL_W-1:0] cmd_col;
   logic             ref_ack;
   logic             bank_open;
   logic [ROW_W-1:0] open_row;

   modport master (
      output req_valid, req_wr, req_row, req_col, ref_tick,
      output act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt,
      input  req_ready, act_req, rd_req, wr_req, pre_req, ref_req,
      input  cmd_row, cmd_col, ref_ack, bank_open, open_row
   );

   modport slave (
      input  req_valid, req_wr, req_row, req_col, ref_tick,
      input  act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt,
      output req_ready, act_req, rd_req, wr_req, pre_req, ref_req,
      output cmd_row, cmd_col, ref_ack, bank_open, open_row
   );
endinterface

// File: rtl/sal_bk_timer.sv
// Saturating down-counter used for every per-bank timing constraint;
// expired is high whenever the count is zero.
module sal_bk_timer
   import sal_bk_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [TMR_W-1:0] load_val,
   output logic             expired
);

   logic [TMR_W-1:0] cnt_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_reg <= '0;
      end else if (load) begin
         cnt_reg <= load_val;
      end else if (cnt_reg != '0) begin
         cnt_reg <= cnt_reg - 1'b1;
      end
   end

   assign expired = (cnt_reg == '0);

endmodule

// File: rtl/sal_bk_ctrl.sv
// Per-bank DDR2 controller: single pending request, bank state tracking and
// timing enforcement. SAL_BK_CLOSE_PAGE_EN selects closed-page policy.
module sal_bk_ctrl
   import sal_bk_pkg::*;
#(
   parameter int ROW_W = 14,
   parameter int COL_W = 10,
   parameter int T_RCD = DEF_T_RCD,
   parameter int T_RP  = DEF_T_RP,
   parameter int T_RAS = DEF_T_RAS,
   parameter int T_RTP = DEF_T_RTP,
   parameter int T_WR  = DEF_T_WR,
   parameter int T_CCD = DEF_T_CCD,
   parameter int T_RFC = DEF_T_RFC
) (
   input logic          clk,
   input logic          rst,
   sal_bk_ctrl_if.slave bus
);

`ifdef SAL_BK_CLOSE_PAGE_EN
   localparam bit CLOSE_PAGE = 1'b1;
`else
   localparam bit CLOSE_PAGE = 1'b0;
`endif

   bk_state_t        state_reg;
   bk_state_t        state_next;

   logic             pend_v_reg;
   logic             pend_wr_reg;
   logic [ROW_W-1:0] pend_row_reg;
   logic [COL_W-1:0] pend_col_reg;
   logic             ref_pend_reg;
   logic [ROW_W-1:0] open_row_reg;

   logic             act_req;
   logic             rd_req;
   logic             wr_req;
   logic             pre_req;
   logic             ref_req;

   logic             act_fire;
   logic             rd_fire;
   logic             wr_fire;
   logic             pre_fire;
   logic             ref_fire;
   logic             accept;
   logic             req_ready;

   logic             eff_idle;
   logic             eff_active;
   logic             row_hit;
   logic             pre_want;
   logic             pre_tmr_ok;

   logic [TMR_CNT-1:0] tmr_load;
   logic [TMR_CNT-1:0] tmr_exp;
   logic [TMR_W-1:0]   tmr_val [TMR_CNT];

   // Grants only count when the matching request is up.
   assign act_fire = act_req & bus.act_gnt;
   assign rd_fire  = rd_req  & bus.rd_gnt;
   assign wr_fire  = wr_req  & bus.wr_gnt;
   assign pre_fire = pre_req & bus.pre_gnt;
   assign ref_fire = ref_req & bus.ref_gnt;

   assign req_ready = ~pend_v_reg | rd_fire | wr_fire;
   assign accept    = bus.req_valid & req_ready;

   assign tmr_load[TMR_RCD] = act_fire;
   assign tmr_load[TMR_RAS] = act_fire;
   assign tmr_load[TMR_RTP] = rd_fire;
   assign tmr_load[TMR_WR]  = wr_fire;
   assign tmr_load[TMR_CCD] = rd_fire | wr_fire;
   assign tmr_load[TMR_RPF] = pre_fire | ref_fire;

   assign tmr_val[TMR_RCD] = tmr_ld(T_RCD);
   assign tmr_val[TMR_RAS] = tmr_ld(T_RAS);
   assign tmr_val[TMR_RTP] = tmr_ld(T_RTP);
   assign tmr_val[TMR_WR]  = tmr_ld(T_WR);
   assign tmr_val[TMR_CCD] = tmr_ld(T_CCD);
   assign tmr_val[TMR_RPF] = pre_fire ? tmr_ld(T_RP) : tmr_ld(T_RFC);

   generate
      for (genvar gi = 0; gi < TMR_CNT; gi++) begin : g_tmr
         sal_bk_timer u_tmr (
            .clk      (clk),
            .rst      (rst),
            .load     (tmr_load[gi]),
            .load_val (tmr_val[gi]),
            .expired  (tmr_exp[gi])
         );
      end
   endgenerate

   // The cycle a wait timer hits zero the bank already behaves as its
   // destination state, so a dependent request lands exactly at N+T.
   assign eff_idle   = (state_reg == BK_IDLE) |
                       (((state_reg == BK_PRECHARGING) | (state_reg == BK_REFRESHING)) &
                        tmr_exp[TMR_RPF]);
   assign eff_active = (state_reg == BK_ACTIVE) |
                       ((state_reg == BK_ACTIVATING) & tmr_exp[TMR_RCD]);

   assign row_hit    = (pend_row_reg == open_row_reg);
   assign pre_want   = ref_pend_reg | (pend_v_reg & ~row_hit) | (CLOSE_PAGE & ~pend_v_reg);
   assign pre_tmr_ok = tmr_exp[TMR_RAS] & tmr_exp[TMR_RTP] & tmr_exp[TMR_WR];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= BK_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      if (eff_idle) begin
         if (act_fire) begin
            state_next = BK_ACTIVATING;
         end else if (ref_fire) begin
            state_next = BK_REFRESHING;
         end else begin
            state_next = BK_IDLE;
         end
      end else if (eff_active) begin
         if (pre_fire) begin
            state_next = BK_PRECHARGING;
         end else begin
            state_next = BK_ACTIVE;
         end
      end
   end

   // Requests come from registered state only; a pending refresh blocks new
   // column and activate traffic so the bank drains towards REF.
   always_comb begin
      ref_req = eff_idle & ref_pend_reg;
      act_req = eff_idle & pend_v_reg & ~ref_pend_reg;
      rd_req  = eff_active & pend_v_reg & row_hit & ~ref_pend_reg &
                tmr_exp[TMR_CCD] & ~pend_wr_reg;
      wr_req  = eff_active & pend_v_reg & row_hit & ~ref_pend_reg &
                tmr_exp[TMR_CCD] & pend_wr_reg;
      pre_req = eff_active & pre_want & pre_tmr_ok;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_v_reg   <= 1'b0;
         pend_wr_reg  <= 1'b0;
         pend_row_reg <= '0;
         pend_col_reg <= '0;
         ref_pend_reg <= 1'b0;
         open_row_reg <= '0;
      end else begin
         if (accept) begin
            pend_v_reg   <= 1'b1;
            pend_wr_reg  <= bus.req_wr;
            pend_row_reg <= bus.req_row;
            pend_col_reg <= bus.req_col;
         end else if (rd_fire | wr_fire) begin
            pend_v_reg   <= 1'b0;
         end

         if (ref_fire) begin
            ref_pend_reg <= 1'b0;
         end else if (bus.ref_tick) begin
            ref_pend_reg <= 1'b1;
         end

         if (act_fire) begin
            open_row_reg <= pend_row_reg;
         end
      end
   end

   assign bus.req_ready = req_ready;
   assign bus.act_req   = act_req;
   assign bus.rd_req    = rd_req;
   assign bus.wr_req    = wr_req;
   assign bus.pre_req   = pre_req;
   assign bus.ref_req   = ref_req;
   assign bus.cmd_row   = pend_row_reg;
   assign bus.cmd_col   = pend_col_reg;
   assign bus.ref_ack   = ref_fire;
   assign bus.bank_open = eff_active;
   assign bus.open_row  = open_row_reg;

endmodule

// File: tb/tb_sal_bk_ctrl.sv
// Bench for sal_bk_ctrl: directed scenarios plus random traffic, checked
// against a timestamp-based model of the bank timing rules.
module tb_sal_bk_ctrl;
   import sal_bk_pkg::*;

   localparam int ROW_W = 14;
   localparam int COL_W = 10;
   localparam int T_RCD = DEF_T_RCD;
   localparam int T_RP  = DEF_T_RP;
   localparam int T_RAS = DEF_T_RAS;
   localparam int T_RTP = DEF_T_RTP;
   localparam int T_WR  = DEF_T_WR;
   localparam int T_CCD = DEF_T_CCD;
   localparam int T_RFC = DEF_T_RFC;
   localparam int NEVER = -1000;

`ifdef SAL_BK_CLOSE_PAGE_EN
   localparam bit CP = 1'b1;
`else
   localparam bit CP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sal_bk_ctrl_if #(.ROW_W(ROW_W), .COL_W(COL_W)) bus ();

   sal_bk_ctrl #(.ROW_W(ROW_W), .COL_W(COL_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always @(posedge clk) begin
      if (!rst) begin
         assert (!((bus.act_gnt && !bus.act_req) || (bus.rd_gnt && !bus.rd_req) ||
                   (bus.wr_gnt && !bus.wr_req) || (bus.pre_gnt && !bus.pre_req) ||
                   (bus.ref_gnt && !bus.ref_req)))
         else $error("FAIL gnt_without_req at time %0t", $time);
      end
   end

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;
   int first_act = -1;
   int first_rd  = -1;

   // Model: a bank is either open on a row or closed, plus grant timestamps.
   bit m_pend_v, m_pend_wr, m_ref_pend, m_open;
   int m_pend_row, m_pend_col, m_orow;
   int t_act, t_pre, t_ref, t_rd, t_wr, t_cas;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_pend_v = 0; m_pend_wr = 0; m_ref_pend = 0; m_open = 0;
      m_pend_row = 0; m_pend_col = 0; m_orow = 0;
      t_act = NEVER; t_pre = NEVER; t_ref = NEVER;
      t_rd = NEVER; t_wr = NEVER; t_cas = NEVER;
   endtask

   task automatic drive_idle();
      bus.req_valid = 0; bus.req_wr = 0; bus.req_row = '0; bus.req_col = '0;
      bus.ref_tick = 0;
      bus.act_gnt = 0; bus.rd_gnt = 0; bus.wr_gnt = 0; bus.pre_gnt = 0; bus.ref_gnt = 0;
   endtask

   task automatic chk_reset_outputs();
      chk("rst_reqs", {bus.act_req, bus.rd_req, bus.wr_req, bus.pre_req, bus.ref_req}, 0);
      chk("rst_ready", bus.req_ready, 1);
      chk("rst_bank_open", bus.bank_open, 0);
      chk("rst_open_row", bus.open_row, 0);
      chk("rst_cmd_row", bus.cmd_row, 0);
      chk("rst_cmd_col", bus.cmd_col, 0);
      chk("rst_ref_ack", bus.ref_ack, 0);
   endtask

   // One clock cycle, entered and left at the falling edge.
   task automatic step(input bit v, input bit w, input int row, input int col,
                       input bit tick, input int gpct);
      bit idle_ok, act_ok, hit, pre_want, pre_tm;
      bit e_act, e_rd, e_wr, e_pre, e_ref, e_rdy;
      bit g_act, g_rd, g_wr, g_pre, g_ref;

      idle_ok  = !m_open && (cyc >= t_pre + T_RP) && (cyc >= t_ref + T_RFC);
      act_ok   = m_open && (cyc >= t_act + T_RCD);
      hit      = m_pend_v && (m_pend_row == m_orow);
      e_ref    = idle_ok && m_ref_pend;
      e_act    = idle_ok && m_pend_v && !m_ref_pend;
      e_rd     = act_ok && hit && !m_ref_pend && !m_pend_wr && (cyc >= t_cas + T_CCD);
      e_wr     = act_ok && hit && !m_ref_pend &&  m_pend_wr && (cyc >= t_cas + T_CCD);
      pre_want = m_ref_pend || (m_pend_v && !hit) || (CP && !m_pend_v);
      pre_tm   = (cyc >= t_act + T_RAS) && (cyc >= t_rd + T_RTP) && (cyc >= t_wr + T_WR);
      e_pre    = act_ok && pre_want && pre_tm;

      if (bus.act_req && first_act < 0) first_act = cyc;
      if (bus.rd_req && first_rd < 0) first_rd = cyc;

      chk("reqs", {bus.act_req, bus.rd_req, bus.wr_req, bus.pre_req, bus.ref_req},
          {e_act, e_rd, e_wr, e_pre, e_ref});
      chk("bank_open", bus.bank_open, act_ok);
      chk("open_row", bus.open_row, m_orow);
      chk("cmd_row", bus.cmd_row, m_pend_row);
      chk("cmd_col", bus.cmd_col, m_pend_col);

      g_act = e_act && ($urandom_range(99) < gpct);
      g_rd  = e_rd  && ($urandom_range(99) < gpct);
      g_wr  = e_wr  && ($urandom_range(99) < gpct);
      g_pre = e_pre && ($urandom_range(99) < gpct);
      g_ref = e_ref && ($urandom_range(99) < gpct);

      bus.req_valid = v;
      bus.req_wr    = w;
      bus.req_row   = ROW_W'(row);
      bus.req_col   = COL_W'(col);
      bus.ref_tick  = tick;
      bus.act_gnt = g_act; bus.rd_gnt = g_rd; bus.wr_gnt = g_wr;
      bus.pre_gnt = g_pre; bus.ref_gnt = g_ref;
      #1;
      e_rdy = !m_pend_v || g_rd || g_wr;
      chk("req_ready", bus.req_ready, e_rdy);
      chk("ref_ack", bus.ref_ack, g_ref);

      if (g_act) begin m_open = 1; m_orow = m_pend_row; t_act = cyc; end
      if (g_pre) begin m_open = 0; t_pre = cyc; end
      if (g_ref) t_ref = cyc;
      if (g_rd) begin t_rd = cyc; t_cas = cyc; end
      if (g_wr) begin t_wr = cyc; t_cas = cyc; end
      if (g_rd || g_wr) m_pend_v = 0;
      if (v && e_rdy) begin
         m_pend_v = 1; m_pend_wr = w; m_pend_row = row; m_pend_col = col;
         $display("cyc %0d accept %s row=%0d col=%0d", cyc, w ? "WR" : "RD", row, col);
      end
      if (g_ref) m_ref_pend = 0;
      else if (tick) m_ref_pend = 1;

      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic idle_steps(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 100);
   endtask

   int rows [4] = '{5, 9, 2, 5};

   initial begin
      drive_idle();
      model_reset();
      rst = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_reset_outputs();
      rst = 0;
      cyc = 0;

      // Read to an idle bank: ACT at 1, RD at 4.
      step(1, 0, 5, 8, 0, 100);
      idle_steps(7);
      chk("s1_first_act", first_act, 1);
      chk("s1_first_rd", first_rd, 4);

      // Back-to-back read hits, then a miss, then write hit followed by a miss.
      step(1, 0, 5, 9, 0, 100);
      step(1, 0, 5, 10, 0, 100);
      idle_steps(4);
      step(1, 0, 9, 1, 0, 100);
      idle_steps(20);
      step(1, 1, 9, 2, 0, 100);
      step(1, 0, 5, 3, 0, 100);
      idle_steps(30);

      // Refresh request arriving together with a pending hit.
      step(1, 0, 5, 4, 1, 100);
      idle_steps(45);

      // Reset while ACTIVATING.
      step(1, 0, 3, 7, 0, 100);
      idle_steps(3);
      step(1, 0, 4, 6, 0, 100);
      step(0, 0, 0, 0, 0, 100);
      rst = 1;
      drive_idle();
      #1;
      chk_reset_outputs();
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 0;
      cyc++;
      idle_steps(3);
      step(1, 0, 6, 5, 0, 100);
      idle_steps(15);

      for (int i = 0; i < 3000; i++) begin
         step(bit'($urandom_range(1)), bit'($urandom_range(1)), rows[$urandom_range(3)],
              int'($urandom_range(1023)), ($urandom_range(99) < 2), 60);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
